// File: rtl/mmm_nlp_pkg.sv
// ============================================================================
// Module : mmm_nlp_pkg
// Brief  : Shared types and constants for the mmm_nlp multiplier arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mmm_nlp_pkg;

  typedef enum logic [1:0] {
    WCFG  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } arb_state_e;

  localparam int MMM_DW  = 256;
  localparam int MMM_MBW = 261;
  localparam int MMM_LAT = 16;

  // Number of bits needed to index 'value' distinct items (minimum 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmm_nlp_rr_arb.sv
// ============================================================================
// Module : mmm_nlp_rr_arb
// Brief  : Combinational round-robin select with a registered start pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmm_nlp_rr_arb
  import mmm_nlp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_vld,
  output logic [NREQ-1:0] o_gnt,
  output logic [TAGW-1:0] o_win,
  output logic            o_hs
);

  logic [TAGW-1:0] ptr_q;
  logic [TAGW-1:0] ptr_d;
  int              idx;

  // Scan from the pointer upward, wrapping at NREQ; first valid wins.
  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_hs  = 1'b0;
    idx   = 0;
    if (i_en) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!o_hs && i_vld[idx[TAGW-1:0]]) begin
          o_hs  = 1'b1;
          o_win = idx[TAGW-1:0];
        end
      end
    end
    if (o_hs) o_gnt[o_win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (o_hs) begin
      if (o_win == TAGW'(NREQ - 1)) ptr_d = '0;
      else                          ptr_d = o_win + TAGW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/mmm_nlp_arbiter.sv
// ============================================================================
// Module : mmm_nlp_arbiter
// Brief  : Round-robin sharing of one pipelined mmm_nlp_256b core among NREQ
//          requesters, with drain-then-load modulus reconfiguration.
//          Optional per-requester grant counters: MMM_NLP_ARB_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmm_nlp_arbiter
  import mmm_nlp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = MMM_DW,
  parameter int MBW  = MMM_MBW,
  parameter int LAT  = MMM_LAT,
  parameter int TAGW = clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [NREQ-1:0]    i_req_vld,
  output logic [NREQ-1:0]    o_req_rdy,
  input  logic [NREQ*DW-1:0] i_req_a,
  input  logic [NREQ*DW-1:0] i_req_b,
  input  logic               i_cfg_vld,
  input  logic [DW-1:0]      i_cfg_m,
  input  logic [MBW-1:0]     i_cfg_m_b,
  output logic               o_cfg_rdy,
  output logic [DW-1:0]      o_core_a,
  output logic [DW-1:0]      o_core_b,
  output logic [DW-1:0]      o_core_m,
  output logic [MBW-1:0]     o_core_m_b,
  input  logic [DW-1:0]      i_core_res,
  output logic [NREQ-1:0]    o_rsp_vld,
  output logic [DW-1:0]      o_rsp_res,
`ifdef MMM_NLP_ARB_PERF_EN
  output logic [NREQ*32-1:0] o_perf_cnt,
`endif
  output logic               o_idle
);

  localparam int OCW = clog2(LAT + 2);

  arb_state_e      state_q;
  logic            cfg_rdy_q;
  logic [DW-1:0]   core_m_q;
  logic [MBW-1:0]  core_m_b_q;
  logic [DW-1:0]   core_a_q, core_a_d;
  logic [DW-1:0]   core_b_q, core_b_d;
  logic [LAT-1:0]  pv_q;
  logic [TAGW-1:0] pt_q [LAT];
  logic [NREQ-1:0] rsp_vld_q;
  logic [DW-1:0]   rsp_res_q;
  logic [OCW-1:0]  outst_q;

  logic            grant_en;
  logic [NREQ-1:0] gnt;
  logic [TAGW-1:0] win;
  logic            hs;
  logic            retire;

  // A cfg request blocks grants in the very cycle it is first seen in RUN.
  assign grant_en = (state_q == RUN) && !i_cfg_vld;

  mmm_nlp_rr_arb #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_rr_arb (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en   (grant_en),
    .i_vld  (i_req_vld),
    .o_gnt  (gnt),
    .o_win  (win),
    .o_hs   (hs)
  );

  assign o_req_rdy = gnt;

  // New modulus is latched on entry to LOAD, so it is visible while cfg_rdy
  // is high; the pipe is already empty at that point.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= WCFG;
      cfg_rdy_q  <= 1'b0;
      core_m_q   <= '0;
      core_m_b_q <= '0;
    end else begin
      cfg_rdy_q <= 1'b0;
      unique case (state_q)
        WCFG: begin
          if (i_cfg_vld) begin
            state_q    <= LOAD;
            cfg_rdy_q  <= 1'b1;
            core_m_q   <= i_cfg_m;
            core_m_b_q <= i_cfg_m_b;
          end
        end
        RUN: begin
          if (i_cfg_vld) state_q <= DRAIN;
        end
        DRAIN: begin
          if (outst_q == '0) begin
            state_q    <= LOAD;
            cfg_rdy_q  <= 1'b1;
            core_m_q   <= i_cfg_m;
            core_m_b_q <= i_cfg_m_b;
          end
        end
        LOAD: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= WCFG;
        end
      endcase
    end
  end

  always_comb begin
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    if (hs) begin
      core_a_d = i_req_a[win*DW +: DW];
      core_b_d = i_req_b[win*DW +: DW];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      core_a_q <= '0;
      core_b_q <= '0;
    end else begin
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
    end
  end

  // Tag shadow pipe: aligned so stage LAT-1 coincides with i_core_res.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pv_q <= '0;
      for (int i = 0; i < LAT; i++) pt_q[i] <= '0;
    end else begin
      pv_q    <= {pv_q[LAT-2:0], hs};
      pt_q[0] <= win;
      for (int i = 1; i < LAT; i++) pt_q[i] <= pt_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
    end else if (pv_q[LAT-1]) begin
      rsp_vld_q <= {{(NREQ-1){1'b0}}, 1'b1} << pt_q[LAT-1];
      rsp_res_q <= i_core_res;
    end else begin
      rsp_vld_q <= '0;
    end
  end

  // An op stays outstanding until its response register has been presented.
  assign retire = |rsp_vld_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      outst_q <= '0;
    end else if (hs && !retire) begin
      outst_q <= outst_q + OCW'(1);
    end else if (!hs && retire) begin
      outst_q <= outst_q - OCW'(1);
    end
  end

`ifdef MMM_NLP_ARB_PERF_EN
  logic [31:0] perf_q [NREQ];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NREQ; i++) perf_q[i] <= '0;
    end else if (state_q == LOAD) begin
      for (int i = 0; i < NREQ; i++) perf_q[i] <= '0;
    end else if (hs) begin
      perf_q[win] <= perf_q[win] + 32'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    assign o_perf_cnt[g*32 +: 32] = perf_q[g];
  end
`endif

  assign o_cfg_rdy  = cfg_rdy_q;
  assign o_core_a   = core_a_q;
  assign o_core_b   = core_b_q;
  assign o_core_m   = core_m_q;
  assign o_core_m_b = core_m_b_q;
  assign o_rsp_vld  = rsp_vld_q;
  assign o_rsp_res  = rsp_res_q;
  assign o_idle     = (state_q == RUN) && (outst_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_mmm_nlp_arbiter.sv
// ============================================================================
// Module : tb_mmm_nlp_arbiter
// Brief  : Self-checking bench for mmm_nlp_arbiter (grant tables, latency,
//          reconfiguration, reset, optional MMM_NLP_ARB_PERF_EN counters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmm_nlp_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 256;
  localparam int MBW  = 261;
  localparam int LAT  = 16;

  localparam logic [DW-1:0]  M1  = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
  localparam logic [MBW-1:0] MB1 = 261'h1_0000_0000_0000_03d1;
  localparam logic [DW-1:0]  M2  = 256'h1234_5678_9abc_def0_0fed_cba9_8765_4321_1111_2222_3333_4444_5555_6666_7777_8889;
  localparam logic [MBW-1:0] MB2 = 261'h1f_dead_beef_cafe_f00d;

  logic               i_clk = 1'b0;
  logic               i_rstn = 1'b0;
  logic [NREQ-1:0]    i_req_vld = '0;
  logic [NREQ-1:0]    o_req_rdy;
  logic [NREQ*DW-1:0] i_req_a = '0;
  logic [NREQ*DW-1:0] i_req_b = '0;
  logic               i_cfg_vld = 1'b0;
  logic [DW-1:0]      i_cfg_m = '0;
  logic [MBW-1:0]     i_cfg_m_b = '0;
  logic               o_cfg_rdy;
  logic [DW-1:0]      o_core_a, o_core_b, o_core_m;
  logic [MBW-1:0]     o_core_m_b;
  logic [DW-1:0]      i_core_res;
  logic [NREQ-1:0]    o_rsp_vld;
  logic [DW-1:0]      o_rsp_res;
  logic               o_idle;
`ifdef MMM_NLP_ARB_PERF_EN
  logic [NREQ*32-1:0] o_perf_cnt;
`endif

  mmm_nlp_arbiter #(.NREQ(NREQ), .DW(DW), .MBW(MBW), .LAT(LAT)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_req_vld  (i_req_vld),
    .o_req_rdy  (o_req_rdy),
    .i_req_a    (i_req_a),
    .i_req_b    (i_req_b),
    .i_cfg_vld  (i_cfg_vld),
    .i_cfg_m    (i_cfg_m),
    .i_cfg_m_b  (i_cfg_m_b),
    .o_cfg_rdy  (o_cfg_rdy),
    .o_core_a   (o_core_a),
    .o_core_b   (o_core_b),
    .o_core_m   (o_core_m),
    .o_core_m_b (o_core_m_b),
    .i_core_res (i_core_res),
    .o_rsp_vld  (o_rsp_vld),
    .o_rsp_res  (o_rsp_res),
`ifdef MMM_NLP_ARB_PERF_EN
    .o_perf_cnt (o_perf_cnt),
`endif
    .o_idle     (o_idle)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] rdy;
  } vec_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] vld;
    logic [DW-1:0]   res;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            cfg_pulses = 0;
  rsp_t          log_q[$];
  rsp_t          exp_q[$];
  logic [DW-1:0] m_cur = '0;
  logic [DW-1:0] core_pipe [LAT-1];

  // Stand-in core: a fixed arithmetic function with the matching latency.
  function automatic logic [DW-1:0] core_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] m);
    return (a ^ {b[127:0], b[255:128]}) + m;
  endfunction

  always @(posedge i_clk) begin
    core_pipe[0] <= core_f(o_core_a, o_core_b, o_core_m);
    for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign i_core_res = core_pipe[LAT-2];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    if (o_rsp_vld != '0) log_q.push_back('{cyc, o_rsp_vld, o_rsp_res});
    if (o_cfg_rdy) cfg_pulses++;
  end

  function automatic logic [DW-1:0] mk_a(input int k, input int n);
    logic [31:0] w;
    w = 32'(k * 4096 + n * 16 + 3);
    return {w, ~w, w + 32'd1, w * 32'd3, w ^ 32'ha5a5a5a5, w, w << 1, w + 32'd7};
  endfunction

  function automatic logic [DW-1:0] mk_b(input int k, input int n);
    logic [31:0] w;
    w = 32'(n * 977 + k * 31 + 11);
    return {w * 32'd5, w, ~w, w + 32'd9, w, w ^ 32'h0f0f0f0f, w >> 1, w};
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [MBW-1:0] act, input logic [MBW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int n);
    for (int k = 0; k < NREQ; k++) begin
      i_req_a[k*DW +: DW] = mk_a(k, n);
      i_req_b[k*DW +: DW] = mk_b(k, n);
    end
  endtask

  // Called at the negedge before the granting edge.
  task automatic push_exp(input logic [NREQ-1:0] gnt, input int n);
    int w;
    w = oh_idx(gnt);
    exp_q.push_back('{cyc + 1 + LAT, gnt, core_f(mk_a(w, n), mk_b(w, n), m_cur)});
  endtask

  task automatic compare_logs(input string tag);
    int nn;
    chk({tag, "_rsp_count"}, MBW'(log_q.size()), MBW'(exp_q.size()));
    nn = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nn; i++) begin
      chk({tag, "_rsp_cyc"}, MBW'(log_q[i].cyc), MBW'(exp_q[i].cyc));
      chk({tag, "_rsp_vld"}, MBW'(log_q[i].vld), MBW'(exp_q[i].vld));
      chk({tag, "_rsp_res"}, MBW'(log_q[i].res), MBW'(exp_q[i].res));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_cfg(input logic [DW-1:0] m, input logic [MBW-1:0] mb);
    int n;
    i_cfg_m   = m;
    i_cfg_m_b = mb;
    i_cfg_vld = 1'b1;
    n = 0;
    do begin
      @(posedge i_clk); #1; n++;
    end while (!o_cfg_rdy && n < 200);
    chk("cfg_done", MBW'(o_cfg_rdy), MBW'(1));
    i_cfg_vld = 1'b0;
    m_cur = m;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge i_clk); #1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int t, n, bad_rdy, bad_m, p0;

    // Grant table: pointer starts at 3 after the single op to requester 2.
    vecs.push_back('{4'b1000, 4'b1000});
    for (int r = 0; r < 3; r++) begin
      vecs.push_back('{4'b1111, 4'b0001});
      vecs.push_back('{4'b1111, 4'b0010});
      vecs.push_back('{4'b1111, 4'b0100});
      vecs.push_back('{4'b1111, 4'b1000});
    end
    vecs.push_back('{4'b0000, 4'b0000});
    vecs.push_back('{4'b1010, 4'b0010});
    vecs.push_back('{4'b1010, 4'b1000});
    vecs.push_back('{4'b0001, 4'b0001});
    vecs.push_back('{4'b0001, 4'b0001});
    vecs.push_back('{4'b0110, 4'b0010});
    vecs.push_back('{4'b0110, 4'b0100});
    vecs.push_back('{4'b0011, 4'b0001});

    // Reset state
    i_req_vld = 4'b1111;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rdy", MBW'(o_req_rdy), '0);
    chk("rst_rsp_vld", MBW'(o_rsp_vld), '0);
    chk("rst_cfg_rdy", MBW'(o_cfg_rdy), '0);
    chk("rst_idle", MBW'(o_idle), '0);
    chk("rst_core_m", MBW'(o_core_m), '0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("wcfg_no_grant", MBW'(o_req_rdy), '0);
    i_req_vld = '0;
    @(posedge i_clk); #1;

    do_cfg(M1, MB1);
    chk("load_m", MBW'(o_core_m), MBW'(M1));
    chk("load_mb", o_core_m_b, MB1);
    @(posedge i_clk); #1;
    chk("run_idle", MBW'(o_idle), MBW'(1));

    // Single op from requester 2
    i_req_vld = 4'b0100;
    set_ops(100);
    @(negedge i_clk);
    chk("single_rdy", MBW'(o_req_rdy), MBW'(4'b0100));
    push_exp(4'b0100, 100);
    t = cyc + 1;
    @(posedge i_clk); #1;
    i_req_vld = '0;
    chk("single_core_a", MBW'(o_core_a), MBW'(mk_a(2, 100)));
    chk("single_core_b", MBW'(o_core_b), MBW'(mk_b(2, 100)));
    wait_cyc(t + LAT - 1);
    chk("single_early_vld", MBW'(o_rsp_vld), '0);
    wait_cyc(t + LAT);
    chk("single_rsp_vld", MBW'(o_rsp_vld), MBW'(4'b0100));
    chk("single_idle_busy", MBW'(o_idle), '0);
    wait_cyc(t + LAT + 1);
    chk("single_rsp_off", MBW'(o_rsp_vld), '0);
    chk("single_idle", MBW'(o_idle), MBW'(1));
    compare_logs("single");

    // Table-driven grant sequence, back-to-back
    for (int v = 0; v < vecs.size(); v++) begin
      i_req_vld = vecs[v].vld;
      set_ops(v);
      @(negedge i_clk);
      chk($sformatf("vec%0d_rdy", v), MBW'(o_req_rdy), MBW'(vecs[v].rdy));
      if (vecs[v].rdy != '0) push_exp(vecs[v].rdy, v);
      @(posedge i_clk); #1;
    end
    i_req_vld = '0;
    repeat (LAT + 3) @(posedge i_clk);
    #1;
    compare_logs("table");

    // Reconfiguration with 5 ops in flight
    for (int j = 0; j < 5; j++) begin
      i_req_vld = 4'b0010;
      set_ops(200 + j);
      @(negedge i_clk);
      chk("rcfg_issue_rdy", MBW'(o_req_rdy), MBW'(4'b0010));
      push_exp(4'b0010, 200 + j);
      @(posedge i_clk); #1;
    end
    i_req_vld = 4'b1111;
    set_ops(300);
    i_cfg_m = M2;
    i_cfg_m_b = MB2;
    i_cfg_vld = 1'b1;
    p0 = cfg_pulses;
    bad_rdy = 0;
    bad_m = 0;
    n = 0;
    do begin
      @(negedge i_clk); n++;
      if (o_req_rdy != '0) bad_rdy++;
      if (!o_cfg_rdy && o_core_m !== M1) bad_m++;
    end while (!o_cfg_rdy && n < 100);
    chk("rcfg_cfg_rdy", MBW'(o_cfg_rdy), MBW'(1));
    chk("rcfg_no_grant", MBW'(bad_rdy), '0);
    chk("rcfg_m_held", MBW'(bad_m), '0);
    chk("rcfg_m_new", MBW'(o_core_m), MBW'(M2));
    chk("rcfg_mb_new", o_core_m_b, MB2);
    chk("rcfg_drained", MBW'(log_q.size()), MBW'(5));
    i_cfg_vld = 1'b0;
    m_cur = M2;
    @(negedge i_clk);
    chk("rcfg_resume_rdy", MBW'(o_req_rdy), MBW'(4'b0100));
    push_exp(4'b0100, 300);
    @(posedge i_clk); #1;
    i_req_vld = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rcfg_one_pulse", MBW'(cfg_pulses - p0), MBW'(1));
    repeat (LAT + 3) @(posedge i_clk);
    #1;
    compare_logs("rcfg");

    // cfg request in the same cycle as a request
    i_req_vld = 4'b0001;
    set_ops(400);
    i_cfg_m = M1;
    i_cfg_m_b = MB1;
    i_cfg_vld = 1'b1;
    @(negedge i_clk);
    chk("same_cyc_no_grant", MBW'(o_req_rdy), '0);
    @(posedge i_clk); #1;
    chk("same_cyc_not_run", MBW'(o_idle), '0);
    bad_rdy = 0;
    n = 0;
    do begin
      @(negedge i_clk); n++;
      if (o_req_rdy != '0) bad_rdy++;
    end while (!o_cfg_rdy && n < 100);
    chk("same_cyc_cfg_rdy", MBW'(o_cfg_rdy), MBW'(1));
    chk("same_cyc_hold", MBW'(bad_rdy), '0);
    i_cfg_vld = 1'b0;
    m_cur = M1;
    @(negedge i_clk);
    chk("same_cyc_after_load", MBW'(o_req_rdy), MBW'(4'b0001));
    push_exp(4'b0001, 400);
    @(posedge i_clk); #1;
    i_req_vld = '0;
    repeat (LAT + 3) @(posedge i_clk);
    #1;
    compare_logs("same_cyc");

    // Asynchronous reset with 3 ops in flight
    i_req_vld = 4'b0111;
    set_ops(500);
    @(negedge i_clk); chk("rst_issue0", MBW'(o_req_rdy), MBW'(4'b0010));
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("rst_issue1", MBW'(o_req_rdy), MBW'(4'b0100));
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("rst_issue2", MBW'(o_req_rdy), MBW'(4'b0001));
    @(posedge i_clk); #1;
    i_req_vld = 4'b1111;
    repeat (8) @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("arst_rdy", MBW'(o_req_rdy), '0);
    chk("arst_rsp_res", MBW'(o_rsp_res), '0);
    chk("arst_core_a", MBW'(o_core_a), '0);
    chk("arst_core_m", MBW'(o_core_m), '0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("arst_hold_rdy", MBW'(o_req_rdy), '0);
    chk("arst_hold_rsp_vld", MBW'(o_rsp_vld), '0);
    chk("arst_hold_core_b", MBW'(o_core_b), '0);
    chk("arst_hold_core_mb", o_core_m_b, '0);
    chk("arst_hold_cfg_rdy", MBW'(o_cfg_rdy), '0);
    chk("arst_hold_idle", MBW'(o_idle), '0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("arst_wcfg_no_grant", MBW'(o_req_rdy), '0);
    i_req_vld = '0;
    repeat (LAT + 5) @(posedge i_clk);
    #1;
    chk("arst_no_responses", MBW'(log_q.size()), '0);
    log_q.delete();

`ifdef MMM_NLP_ARB_PERF_EN
    do_cfg(M1, MB1);
    @(posedge i_clk); #1;
    for (int j = 0; j < 7; j++) begin
      i_req_vld = 4'b0010;
      set_ops(600 + j);
      @(negedge i_clk);
      chk("perf_issue_rdy", MBW'(o_req_rdy), MBW'(4'b0010));
      push_exp(4'b0010, 600 + j);
      @(posedge i_clk); #1;
    end
    i_req_vld = '0;
    chk("perf_cnt_7", MBW'(o_perf_cnt), MBW'({32'd0, 32'd0, 32'd7, 32'd0}));
    do_cfg(M2, MB2);
    @(posedge i_clk); #1;
    chk("perf_cnt_clear", MBW'(o_perf_cnt), '0);
    compare_logs("perf");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmm_nlp_arbiter.md
Name: mmm_nlp_arbiter

Overview:
Round-robin scheduler that shares one fully pipelined mmm_nlp_256b Montgomery multiplier core among NREQ requesters.
- Issues at most one operand pair per cycle into the core.
- Tracks each in-flight operation's requester tag through a latency-matched shadow pipe and routes each result back to its originator.
- Owns the shared modulus registers (m, m_b) and sequences modulus reconfiguration: stop issue, drain the pipe, load, resume.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 256, operand/result width
MBW, 261, width of precomputed m_b
LAT, 16, core latency in cycles, from registered core inputs to valid i_core_res
TAGW, 2, requester tag width, clog2(NREQ)

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
i_req_vld  in  NREQ  per-requester operation valid
o_req_rdy  out  NREQ  one-hot grant; handshake = vld&rdy
i_req_a  in  NREQ*DW  flattened operand a, requester k at [k*DW +: DW]
i_req_b  in  NREQ*DW  flattened operand b
i_cfg_vld  in  1  modulus load request; held until o_cfg_rdy
i_cfg_m  in  DW  new modulus
i_cfg_m_b  in  MBW  new precomputed m_b
o_cfg_rdy  out  1  one-cycle pulse: cfg loaded
o_core_a  out  DW  registered operand a to core
o_core_b  out  DW  registered operand b to core
o_core_m  out  DW  modulus register to core
o_core_m_b  out  MBW  m_b register to core
i_core_res  in  DW  core result
o_rsp_vld  out  NREQ  one-hot response valid, registered
o_rsp_res  out  DW  response data, registered, shared by all requesters
o_idle  out  1  state==RUN and outstanding==0

Behaviour:
- Reset values: all outputs 0, state=WCFG, round-robin pointer=0, outstanding=0, shadow pipe cleared.
- States:
  - WCFG: no grants; on i_cfg_vld go to LOAD.
  - RUN: grants allowed; on i_cfg_vld go to DRAIN, and no grant is issued in that same cycle.
  - DRAIN: no grants; when outstanding==0 go to LOAD.
  - LOAD: capture i_cfg_m/i_cfg_m_b into o_core_m/o_core_m_b, assert o_cfg_rdy for exactly this cycle, then go to RUN.
- Grant (RUN only): o_req_rdy is combinational from i_req_vld. Search starts at the pointer, wrapping modulo NREQ. The first valid requester gets rdy. After a handshake the pointer moves to winner+1 (wrap NREQ-1 to 0); otherwise it holds. Requesters must not make vld depend on rdy.
- Issue: on handshake at edge t, o_core_a/o_core_b take the winner's operands, and the shadow pipe stage 0 takes {1, tag}. Without a handshake, o_core_a/o_core_b hold their values and stage 0 takes valid=0.
- Shadow pipe: LAT stages of {valid, tag}, advancing every cycle with no stall. At stage LAT-1 with valid set: o_rsp_res <= i_core_res and o_rsp_vld <= onehot(tag) at the next edge. Otherwise o_rsp_vld <= 0 and o_rsp_res holds.
- Latency: handshake edge t gives o_rsp_vld high in cycle t+LAT+1. Throughput is 1 op/cycle. No response backpressure; requesters must accept.
- Outstanding counter: width clog2(LAT+2). +1 on issue, -1 on retire; unchanged when both happen in the same cycle. Saturation is impossible because the maximum is LAT+1.
- o_core_m/o_core_m_b change only in LOAD, so the core never sees a modulus change with operations in flight.
- Reset mid-operation: in-flight ops are discarded with no responses, state returns to WCFG, and the modulus clears to 0.
- i_cfg_vld during DRAIN or LOAD is ignored beyond the current request. A request held across LOAD starts a new load only after a gap cycle: RUN sees vld, returns to DRAIN, then LOAD.

Optional Feature:
MMM_NLP_ARB_PERF_EN
- Defined: adds output o_perf_cnt, width NREQ*32, flattened as per-requester 32-bit grant counters. Each counter increments on that requester's handshake and wraps at 2^32-1 to 0. Counters reset to 0 asynchronously and also clear on the LOAD state.
- Undefined: port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package mmm_nlp_pkg holds:
  - State encoding: WCFG=2'd0, RUN=2'd1, DRAIN=2'd2, LOAD=2'd3.
  - Constants MMM_DW=256, MMM_MBW=261, MMM_LAT=16.
  - Function clog2.
- One sub-module, mmm_nlp_rr_arb: combinational round-robin priority select plus the registered pointer, parameterised by NREQ. Shadow pipe and FSM stay in the top.

Test Plan:
- Single op, NREQ=4, LAT=16: cfg m=fffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f, then requester 2 issues once at edge t. Expect o_rsp_vld=4'b0100 at t+17 only, o_rsp_res equals the core model output, and o_idle=1 from t+18.
- All four vld held for 12 cycles: grants rotate 0,1,2,3,0,… with exactly 3 grants each. Responses arrive in the same order, one per cycle, 17 cycles after each grant.
- Reconfig with 5 ops in flight: o_req_rdy=0 from the cfg cycle on, all 5 responses delivered, then o_cfg_rdy pulses once and o_core_m updates only in that cycle. Grants resume the next cycle.
- i_cfg_vld raised in the same cycle requester 0 has vld in RUN: no grant that cycle, DRAIN entered, op granted after LOAD.
- Async reset asserted 8 cycles after 3 issues: no o_rsp_vld ever rises for them, and all outputs read 0 while reset is held.
- PERF_EN build: requester 1 issues 7 ops, so o_perf_cnt[63:32]=7 and the others read 0. After a cfg LOAD all read 0.
